// File: rtl/uart_rx_fifo.sv
// 16x oversampled UART receiver (8N1, LSB first) feeding a show-ahead receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity_err pulse.
module uart_rx_fifo #(
  parameter int unsigned sys_clk_freq = 50_000_000,
  parameter int unsigned baudrate     = 115200,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rx_byte,
  output logic       empty,
  output logic       rx_done,
  output logic       frame_err,
  output logic       overflow,
  output logic       parity_err
);

  localparam int unsigned OSR_DIV = sys_clk_freq / (baudrate * 16);
  localparam int unsigned TW      = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TickMax = TW'(OSR_DIV - 1);
  localparam logic [AW:0]   PtrOne  = (AW + 1)'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHigh} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;
`endif

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [2:0]  vld_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]  sample_cnt_q, sample_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  smp_q, smp_d;
  logic [7:0]  shift_q, shift_d;
  logic        frame_err_q, ferr_d;
  logic        parity_err_q, perr_d;
  logic        tick, start_edge, busy, mid, bit_end, maj, push;
`ifdef UART_RX_PARITY_EN
  logic        drop_q, drop_d;
`endif

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        full, pop_fire, push_ok, rx_done_q, overflow_q;

  // vld_q marks when rx_prev_q holds a real pin sample, so a line low at reset release is
  // not mistaken for a start edge against the synchronizer's reset value.
  assign start_edge = (state_q == StIdle) && vld_q[2] && rx_prev_q && !rx_sync_q;
  assign tick       = (tick_cnt_q == '0);
  assign busy       = (state_q != StIdle) && (state_q != StWaitHigh);
  assign mid        = tick && (sample_cnt_q == 4'd9);
  assign bit_end    = tick && (sample_cnt_q == 4'd15);
  assign maj        = (smp_q[0] & smp_q[1]) | (rx_sync_q & (smp_q[0] | smp_q[1]));

  always_comb begin
    if (start_edge || (tick_cnt_q == TickMax)) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    smp_d        = smp_q;
    shift_d      = shift_q;
    push         = 1'b0;
    ferr_d       = 1'b0;
    perr_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
    drop_d       = drop_q;
`endif
    if (busy && tick) begin
      sample_cnt_d = sample_cnt_q + 4'd1;
      if (sample_cnt_q == 4'd7) smp_d[0] = rx_sync_q;
      if (sample_cnt_q == 4'd8) smp_d[1] = rx_sync_q;
    end
    case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d      = StStart;
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
`ifdef UART_RX_PARITY_EN
          drop_d       = 1'b0;
`endif
        end
      end
      StStart: begin
        if (mid && maj) begin
          state_d = StIdle;
        end else if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (mid) shift_d = {maj, shift_q[7:1]};
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        // Even parity: data bits plus parity bit must XOR to zero.
        if (mid && ((^shift_q) ^ maj)) begin
          perr_d = 1'b1;
          drop_d = 1'b1;
        end
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (mid) begin
          if (maj) begin
`ifdef UART_RX_PARITY_EN
            push = !drop_q;
`else
            push = 1'b1;
`endif
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      vld_q        <= '0;
      tick_cnt_q   <= '0;
      state_q      <= StIdle;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      smp_q        <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      drop_q       <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      vld_q        <= {vld_q[1:0], 1'b1};
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      smp_q        <= smp_d;
      shift_q      <= shift_d;
      frame_err_q  <= ferr_d;
      parity_err_q <= perr_d;
`ifdef UART_RX_PARITY_EN
      drop_q       <= drop_d;
`endif
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_fire = rd_en && !empty;
  assign push_ok  = push && (!full || pop_fire);

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_done_q  <= 1'b0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rx_done_q  <= push_ok;
      overflow_q <= push && !push_ok;
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        wr_ptr_q                <= wr_ptr_q + PtrOne;
      end
      if (pop_fire) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  assign rx_byte   = mem_q[rd_ptr_q[AW-1:0]];
  assign rx_done   = rx_done_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame-level scoreboard model checked every cycle, plus literal pins.
module tb_uart_rx_fifo;

  localparam int OSR     = 50_000_000 / (115200 * 16);
  localparam int BIT_CYC = 434;
  localparam int DEPTH   = 4;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
  localparam int LAT_LIT  = 4567;
`else
  localparam int STOP_IDX = 9;
  localparam int LAT_LIT  = 4135;
`endif
  // Pin to push edge: 2 synchronizer edges, 1 edge to register START, tick 9 of the
  // decision bit, then the push edge.
  localparam int LAT  = 3 + OSR * (16 * STOP_IDX + 9) + 1;
  localparam int PLAT = 3 + OSR * (16 * 9 + 9) + 1;

  logic       sclk = 1'b0;
  logic       rst  = 1'b0;
  logic       rx   = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rx_byte;
  logic       empty, rx_done, frame_err, overflow, parity_err;

  uart_rx_fifo dut (
    .sclk      (sclk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .rx_byte   (rx_byte),
    .empty     (empty),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .overflow  (overflow),
    .parity_err(parity_err)
  );

  always #10 sclk = ~sclk;

  typedef struct {int at; int kind; logic [7:0] b;} ev_t;
  ev_t        evq[$];
  logic [7:0] mq[$];
  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, ferr_cnt = 0, ovf_cnt = 0, perr_cnt = 0, last_done_cyc = 0;
  bit chk_en = 1'b0;
  bit exp_done, exp_ferr, exp_ovf, exp_perr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: FIFO contents as a queue, frame outcomes scheduled by the driver.
  always @(posedge sclk) begin
    bit pop, full;
    cyc++;
    exp_done = 1'b0; exp_ferr = 1'b0; exp_ovf = 1'b0; exp_perr = 1'b0;
    if (rst) begin
      mq.delete();
      evq.delete();
    end else begin
      pop  = rd_en && (mq.size() > 0);
      full = (mq.size() == DEPTH);
      if (pop) void'(mq.pop_front());
      while (evq.size() > 0 && evq[0].at == cyc) begin
        case (evq[0].kind)
          0: if (full && !pop) exp_ovf = 1'b1;
             else begin mq.push_back(evq[0].b); exp_done = 1'b1; end
          1: exp_ferr = 1'b1;
          default: exp_perr = 1'b1;
        endcase
        void'(evq.pop_front());
      end
    end
  end

  always @(posedge sclk) begin
    #1;
    if (rx_done) begin done_cnt++; last_done_cyc = cyc; end
    if (frame_err) ferr_cnt++;
    if (overflow) ovf_cnt++;
    if (parity_err) perr_cnt++;
    if (chk_en) begin
      check("empty", empty, mq.size() == 0);
      if (mq.size() > 0) check("rx_byte", rx_byte, mq[0]);
      check("rx_done", rx_done, exp_done);
      check("frame_err", frame_err, exp_ferr);
      check("overflow", overflow, exp_ovf);
      check("parity_err", parity_err, exp_perr);
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par,
                            input int abort_bit, input int stop_bits, output int t0);
    @(negedge sclk);
    t0 = cyc;
    rx = 1'b0;
    if (abort_bit < 0) begin
`ifdef UART_RX_PARITY_EN
      if (bad_par) evq.push_back('{t0 + PLAT, 2, b});
`endif
      if (bad_stop) evq.push_back('{t0 + LAT, 1, b});
      else if (!bad_par) evq.push_back('{t0 + LAT, 0, b});
    end
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_CYC) @(negedge sclk);
      rx = b[i];
      if (i == abort_bit) begin
        repeat (BIT_CYC / 2) @(negedge sclk);
        rst = 1'b1;
        @(negedge sclk);
        check("rst_empty", empty, 1);
        check("rst_byte", rx_byte, 8'h00);
        check("rst_pulses", {rx_done, frame_err, overflow, parity_err}, 4'h0);
        repeat (4) @(negedge sclk);
        rst = 1'b0;
        repeat (300) @(negedge sclk);
        rx = 1'b1;
        repeat (100) @(negedge sclk);
        return;
      end
    end
`ifdef UART_RX_PARITY_EN
    repeat (BIT_CYC) @(negedge sclk);
    rx = (^b) ^ bad_par;
`endif
    repeat (BIT_CYC) @(negedge sclk);
    rx = !bad_stop;
    repeat (BIT_CYC * stop_bits) @(negedge sclk);
    rx = 1'b1;
  endtask

  task automatic pop();
    @(negedge sclk);
    rd_en = 1'b1;
    @(negedge sclk);
    rd_en = 1'b0;
  endtask

  initial begin
    int t0, base_done;
    logic [7:0] exp_b [4];
    #5 rst = 1'b1;
    repeat (3) @(negedge sclk);
    check("reset_empty", empty, 1);
    check("reset_byte", rx_byte, 8'h00);
    check("reset_pulses", {rx_done, frame_err, overflow, parity_err}, 4'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (50) @(negedge sclk);

    // Single byte, latency and pop.
    send_frame(8'h3A, 1'b0, 1'b0, -1, 1, t0);
    check("latency_3a", last_done_cyc - t0, LAT_LIT);
    check("byte_3a", rx_byte, 8'h3A);
    check("nonempty_3a", empty, 0);
    pop();
    check("empty_after_pop", empty, 1);
    pop();
    check("pop_when_empty", empty, 1);

    // Short glitch is a false start.
    base_done = done_cnt;
    @(negedge sclk);
    rx = 1'b0;
    repeat (100) @(negedge sclk);
    rx = 1'b1;
    repeat (600) @(negedge sclk);
    check("glitch_done", done_cnt - base_done, 0);
    check("glitch_ferr", ferr_cnt, 0);

    // Framing error with a long low, then recovery.
    send_frame(8'h55, 1'b1, 1'b0, -1, 3, t0);
    repeat (100) @(negedge sclk);
    check("ferr_once", ferr_cnt, 1);
    check("ferr_empty", empty, 1);
    send_frame(8'hA5, 1'b0, 1'b0, -1, 1, t0);
    check("byte_a5", rx_byte, 8'hA5);
    pop();

    // Back-to-back overflow, then push into full FIFO with a simultaneous pop.
    base_done = done_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, -1, 1, t0);
    check("ovf_done4", done_cnt - base_done, 4);
    check("ovf_once", ovf_cnt, 1);
    fork
      send_frame(8'h06, 1'b0, 1'b0, -1, 1, t0);
      begin
        @(negedge sclk);
        repeat (LAT - 1) @(negedge sclk);
        rd_en = 1'b1;
        @(negedge sclk);
        rd_en = 1'b0;
      end
    join
    check("fullpop_no_ovf", ovf_cnt, 1);
    check("fullpop_done", done_cnt - base_done, 5);
    exp_b[0] = 8'h02; exp_b[1] = 8'h03; exp_b[2] = 8'h04; exp_b[3] = 8'h06;
    for (int i = 0; i < 4; i++) begin
      check("drain_byte", rx_byte, exp_b[i]);
      pop();
    end
    check("drain_empty", empty, 1);

    // Reset mid-frame with the line low at release, then a clean frame.
    send_frame(8'h7E, 1'b0, 1'b0, -1, 1, t0);
    check("byte_7e", rx_byte, 8'h7E);
    base_done = done_cnt;
    send_frame(8'hC3, 1'b0, 1'b0, 4, 1, t0);
    check("abort_no_done", done_cnt - base_done, 0);
    check("abort_empty", empty, 1);
    send_frame(8'hC3, 1'b0, 1'b0, -1, 1, t0);
    check("byte_c3", rx_byte, 8'hC3);
    pop();
`ifdef UART_RX_PARITY_EN
    base_done = done_cnt;
    send_frame(8'hC3, 1'b0, 1'b1, -1, 1, t0);
    check("perr_once", perr_cnt, 1);
    check("perr_no_push", done_cnt - base_done, 0);
    check("perr_empty", empty, 1);
`else
    check("perr_tied", perr_cnt, 0);
`endif
    repeat (20) @(negedge sclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Standalone UART receiver with 16× oversampling, majority-vote bit decisions, framing-error detection and a small show-ahead receive FIFO. It is the receiving end for the byte stream produced by `uart_ctrler` on its `tx` line (8N1, LSB first). It sits between the CH340 RX pin and any byte consumer in the fabric, so the consumer can read at its own pace.

## Interface
Parameters:
- `sys_clk_freq`, default 50_000_000: `sclk` frequency in Hz.
- `baudrate`, default 115200: line rate in bit/s.
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of 2, ≥2.

Ports:
- `sclk`, in, 1: system clock; everything is on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx`, in, 1: asynchronous serial input; idles high.
- `rd_en`, in, 1: pops the FIFO head on this edge if `empty`=0.
- `rx_byte`, out, 8: current FIFO head (show-ahead); valid while `empty`=0.
- `empty`, out, 1: FIFO holds no bytes.
- `rx_done`, out, 1: 1-cycle pulse when a good byte is written into the FIFO.
- `frame_err`, out, 1: 1-cycle pulse when the stop bit is sampled low.
- `overflow`, out, 1: 1-cycle pulse when a good byte is dropped because the FIFO is full.
- `parity_err`, out, 1: 1-cycle pulse when the parity check fails (see Configuration).

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1.
- Oversample tick: `OSR_DIV = sys_clk_freq/(baudrate*16)`, using truncating integer division. The default gives 27, a 0.5% rate error. The tick counter runs freely in IDLE. It is cleared on start-edge detection, so tick 0 lines up with the falling edge.
- `sample_cnt` counts 0..15 ticks per bit. The bit value is the majority of the synchronized samples taken at ticks 7, 8 and 9. The decision is made at tick 9.
- State machine:
  - IDLE: a high→low transition on the synchronized `rx` goes to START.
  - START: if the majority decision is 1, this is a false start; go back to IDLE with no output. If it is 0, continue at the bit boundary to DATA.
  - DATA: 8 bits, shifted in LSB first. After bit 7, go to PARITY if the macro is defined, otherwise go to STOP.
  - PARITY: checks even parity over the data bits plus the parity bit. On failure, pulse `parity_err` and drop the byte. Then go to STOP.
  - STOP: majority 1 → push the byte (unless it was dropped for parity) and return to IDLE immediately after the tick-9 decision. Majority 0 → pulse `frame_err`, drop the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stays here until the synchronized `rx`=1 (this covers a break condition), then goes to IDLE.
- FIFO:
  - Write pointer and read pointer are each `log2(FIFO_DEPTH)+1` bits. Empty when the pointers are equal. Full when the MSBs differ and the remaining bits are equal.
  - Push when full: the byte is dropped and `overflow` pulses; `rx_done` stays 0.
  - Push and pop in the same cycle: both happen, including when full (no overflow) and when non-empty. `rd_en` while empty is ignored.
- Reset values:
  - State IDLE; all counters and pointers 0.
  - `empty`=1, `rx_byte`=8'h00.
  - `rx_done`, `frame_err`, `overflow` and `parity_err` all 0.

## Timing
- Latency: the push happens on the `sclk` edge after the tick-9 stop-bit decision. `rx_done` is high that same cycle, `empty` falls that cycle, and `rx_byte` is valid that cycle.
- From the start falling edge at the pin to `rx_done` is about 9.56 bit times plus 3 `sclk` cycles (2 synchronizer flops plus the register stage).
- Pop: `rx_byte` and `empty` update on the edge that samples `rd_en`=1.
- Returning to IDLE at mid-stop leaves about 7 ticks of margin before the next start edge. Back-to-back frames with a single stop bit are received without loss.
- `rst` asserted mid-frame aborts immediately. After release the block waits for a fresh high→low edge, so a line that is low at release is not taken as a start.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is 8E1 and the PARITY state is compiled in. `parity_err` is live, and a byte that fails parity is never pushed.
- Not defined: the frame is 8N1, the PARITY state is absent, and `parity_err` is tied to 0.

## Test plan
- Send 8'h3A at 115200 baud with `sclk` at 50 MHz → one `rx_done` pulse, `rx_byte`=8'h3A, `empty`=0. One `rd_en` → `empty`=1.
- Hold `rx` low for 2 µs in IDLE (a glitch shorter than half a bit) → no `rx_done`, no `frame_err`, state returns to IDLE.
- Send 8'h55 with the stop bit forced to 0 and held low for 3 bit times → `frame_err` pulses once, `empty` stays 1. The next valid 8'hA5 is received correctly.
- Send 5 back-to-back frames 8'h01..8'h05 with no reads → 4 `rx_done` pulses and 1 `overflow` pulse. Four pops return 01, 02, 03, 04.
- With the FIFO full, assert `rd_en` in the push cycle of a new byte → no `overflow`, the byte is stored, and `empty` stays 0.
- Assert `rst` during data bit 4 → all outputs return to their reset values. The following frame 8'hC3 is received correctly. With `UART_RX_PARITY_EN` defined, 8'hC3 sent with odd parity → `parity_err` pulses and nothing is pushed.
